// File: rtl/word_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : word_serializer_pkg
//  Description : Shared types and defaults for the word serializer.
//                Provides the 2-bit state encoding, the default word width
//                and the default idle line level.
//  Revision    : 1.0  initial release
// ============================================================================
package word_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage : word_serializer_pkg
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_serializer
//  Description : Parallel-to-serial converter. Accepts WIDTH-bit words over a
//                valid/ready handshake and emits them one bit per clock.
//                Optional macro WORD_SERIALIZER_PARITY_EN appends one even
//                parity bit (XOR of the word) after the data bits.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                in_data   - word to serialize (sampled on acceptance only)
//                in_valid  - in_data is valid
//                in_ready  - block can accept a word this cycle
//                ser_out   - serial bit stream (IDLE_BIT when not sending)
//                ser_valid - ser_out carries a live bit
//                busy      - a word is in flight
//  Revision    : 1.0  initial release
// ============================================================================
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_ser_out;
    logic               w_ser_out_nxt;
    logic               r_ser_valid;
    logic               w_ser_valid_nxt;
    logic               r_busy;
    logic               w_ready;
    logic               w_accept;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic               r_parity;
    logic               w_parity_nxt;
`endif

    // The first bit of a word is driven straight from in_data on the accept
    // edge, so the shift register only holds the remaining bits.
    logic               w_load_bit;
    logic [WIDTH-1:0]   w_load_rest;
    logic               w_shift_bit;
    logic [WIDTH-1:0]   w_shift_rest;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_load_bit   = in_data[WIDTH-1];
            assign w_load_rest  = {in_data[WIDTH-2:0], 1'b0};
            assign w_shift_bit  = r_shreg[WIDTH-1];
            assign w_shift_rest = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_bit   = in_data[0];
            assign w_load_rest  = {1'b0, in_data[WIDTH-1:1]};
            assign w_shift_bit  = r_shreg[0];
            assign w_shift_rest = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    // Readiness depends only on registered state and rst, never on in_valid.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:   w_ready = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            ST_PARITY: w_ready = 1'b1;
`else
            ST_SHIFT:  w_ready = (r_cnt == c_cnt_last);
`endif
            default:   w_ready = 1'b0;
        endcase
    end

    assign in_ready = w_ready && !rst;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt     = ST_IDLE;
        w_shreg_nxt     = r_shreg;
        w_cnt_nxt       = r_cnt;
        w_ser_out_nxt   = IDLE_BIT;
        w_ser_valid_nxt = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        w_parity_nxt    = r_parity;
`endif
        case (r_state)
            ST_SHIFT: begin
                if (r_cnt != c_cnt_last) begin
                    w_state_nxt     = ST_SHIFT;
                    w_shreg_nxt     = w_shift_rest;
                    w_cnt_nxt       = r_cnt + c_cnt_w'(1);
                    w_ser_out_nxt   = w_shift_bit;
                    w_ser_valid_nxt = 1'b1;
                end else begin
`ifdef WORD_SERIALIZER_PARITY_EN
                    w_state_nxt     = ST_PARITY;
                    w_ser_out_nxt   = r_parity;
                    w_ser_valid_nxt = 1'b1;
`endif
                end
            end
            default: ;
        endcase

        // Acceptance overrides the fall-back to IDLE; this is what makes
        // back-to-back words seamless.
        if (w_accept) begin
            w_state_nxt     = ST_SHIFT;
            w_shreg_nxt     = w_load_rest;
            w_cnt_nxt       = '0;
            w_ser_out_nxt   = w_load_bit;
            w_ser_valid_nxt = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            w_parity_nxt    = ^in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_ser_out   <= IDLE_BIT;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef WORD_SERIALIZER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign busy      = r_busy;

endmodule : word_serializer
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_serializer
//  Description : Self-checking bench for word_serializer. Drives an MSB-first
//                and an LSB-first instance (WIDTH=8) with the same stimulus
//                and compares both against a word/position model every cycle,
//                plus literal expectations for captured bit streams.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_word_serializer;

    localparam int WIDTH = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready_a, ser_out_a, ser_valid_a, busy_a;
    logic             in_ready_b, ser_out_b, ser_valid_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a), .busy(busy_a)
    );

    word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A word in flight is described by the word and the index of the bit on
    // the line; bit WIDTH (parity builds only) is the XOR of the word.
    bit               m_active = 1'b0;
    int               m_pos    = 0;
    logic [WIDTH-1:0] m_word   = '0;

    function automatic logic seq_bit(input logic [WIDTH-1:0] w, input int pos, input int msb);
        if (pos == WIDTH) return ^w;
        return (msb != 0) ? w[WIDTH-1-pos] : w[pos];
    endfunction

    initial begin : compare_proc
        bit rdy;
        forever begin
            @(posedge clk);
            rdy = !rst && (!m_active || m_pos == LEN-1);
            if (rst) begin
                m_active = 1'b0;
            end else if (in_valid && rdy) begin
                m_word   = in_data;
                m_pos    = 0;
                m_active = 1'b1;
            end else if (m_active && m_pos < LEN-1) begin
                m_pos++;
            end else begin
                m_active = 1'b0;
            end
            @(negedge clk);
            rdy = !rst && (!m_active || m_pos == LEN-1);
            check("in_ready_msb",  in_ready_a,  rdy);
            check("in_ready_lsb",  in_ready_b,  rdy);
            check("ser_valid_msb", ser_valid_a, m_active);
            check("ser_valid_lsb", ser_valid_b, m_active);
            check("busy_msb",      busy_a,      m_active);
            check("busy_lsb",      busy_b,      m_active);
            check("ser_out_msb",   ser_out_a,   m_active ? seq_bit(m_word, m_pos, 1) : 1'b0);
            check("ser_out_lsb",   ser_out_b,   m_active ? seq_bit(m_word, m_pos, 0) : 1'b0);
        end
    end

    // Presents a word, waits (bounded) for acceptance, then captures the
    // WIDTH data bits of each instance in line order and the parity bit.
    task automatic send_word(input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] ca,
                             output logic [WIDTH-1:0] cb, output logic pa);
        int guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready_a && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        check("ready_before_send", in_ready_a, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        ca = '0; cb = '0; pa = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            ca = {ca[WIDTH-2:0], ser_out_a};
            cb = {cb[WIDTH-2:0], ser_out_b};
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        @(negedge clk);
        pa = ser_out_a;
`endif
    endtask

    task automatic check_idle_line(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, ser_valid_a, 1'b0);
        check({tag, "_out"},   ser_out_a,   1'b0);
        check({tag, "_busy"},  busy_a,      1'b0);
    endtask

    initial begin : stim_proc
        logic [WIDTH-1:0] ca, cb;
        logic             pa;
        logic [17:0]      cap;
        int               nbits, gaps, busy_low, ready_seen;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ready_in_rst", in_ready_a, 1'b0);
        check("reset_ser_valid",    ser_valid_a, 1'b0);
        check("reset_busy",         busy_a,      1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset",  in_ready_a, 1'b1);

        // Single word, both shift orders (A5 is its own bit-reverse).
        send_word(8'hA5, ca, cb, pa);
        check("a5_msb_stream", ca, 8'hA5);
        check("a5_lsb_stream", cb, 8'hA5);
        check_idle_line("a5_after");

        // Back-to-back with in_valid held.
        in_data = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #2;
        in_data = 8'h3C;
        cap = '0; nbits = 0; gaps = 0; busy_low = 0; ready_seen = 0;
        for (int cyc = 0; cyc < 40 && nbits < 2*LEN; cyc++) begin
            @(negedge clk);
            if (ser_valid_a) begin
                cap = {cap[16:0], ser_out_a};
                nbits++;
            end else begin
                gaps++;
            end
            if (!busy_a) busy_low++;
            if (in_ready_a && in_valid) begin
                ready_seen++;
                @(posedge clk); #2;
                in_valid = 1'b0;
            end
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        check("b2b_stream", cap, {8'hA5, 1'b0, 8'h3C, 1'b0});
`else
        check("b2b_stream", cap, {2'b00, 8'hA5, 8'h3C});
`endif
        check("b2b_bits",       nbits,      2*LEN);
        check("b2b_gaps",       gaps,       0);
        check("b2b_busy_low",   busy_low,   0);
        check("b2b_ready_once", ready_seen, 1);
        check_idle_line("b2b_after");

        // LSB-first distinguishes order.
        send_word(8'h01, ca, cb, pa);
        check("w01_msb_stream", ca, 8'h01);
        check("w01_lsb_stream", cb, 8'h80);
        check_idle_line("w01_after");

        // Reset while bit 4 of 8'hFF is on the line.
        in_data = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        check("rst_mid_valid_before", ser_valid_a, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_ready_low", in_ready_a, 1'b0);
        @(posedge clk); #2;
        check("rst_mid_valid_after", ser_valid_a, 1'b0);
        check("rst_mid_busy_after",  busy_a,      1'b0);
        rst = 1'b0;
        #1;
        check("rst_mid_ready_back", in_ready_a, 1'b1);
        send_word(8'hB2, ca, cb, pa);
        check("b2_msb_stream", ca, 8'hB2);
        check("b2_lsb_stream", cb, 8'h4D);

        // in_valid with changing data while mid-word must not be sampled.
        @(negedge clk);
        in_data = 8'h6C; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        ca = '0; cb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            ca = {ca[WIDTH-2:0], ser_out_a};
            cb = {cb[WIDTH-2:0], ser_out_b};
            in_valid = (i < 5);
            in_data  = WIDTH'($urandom);
        end
        in_valid = 1'b0;
        check("6c_msb_stream", ca, 8'h6C);
        check("6c_lsb_stream", cb, 8'h36);
        repeat (3) @(negedge clk);
        check("6c_no_resample", ser_valid_a, 1'b0);

`ifdef WORD_SERIALIZER_PARITY_EN
        send_word(8'h07, ca, cb, pa);
        check("p07_data",   ca, 8'h07);
        check("p07_parity", pa, 1'b1);
        check_idle_line("p07_after");
        send_word(8'h03, ca, cb, pa);
        check("p03_data",   ca, 8'h03);
        check("p03_parity", pa, 1'b0);
        check_idle_line("p03_after");
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_word_serializer
`default_nettype wire

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial converter that feeds the single-bit serial sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out.
- ser_out connects directly to the detector's data_in.
- ser_valid marks live bits; between words the line is driven to IDLE_BIT.

Parameters:
- WIDTH, 8, word width in bits; must be at least 2.
- MSB_FIRST, 1, shift order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- IDLE_BIT, 0, level driven on ser_out when no bit is being sent.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial bit stream to the detector's data_in.
- ser_valid  out  1  ser_out carries a live bit.
- busy  out  1  a word is in flight.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset (rst) is synchronous and active-high.
  - On the reset cycle: state=IDLE, ser_out=IDLE_BIT, ser_valid=0, busy=0, shift register and bit counter cleared.
  - in_ready is 0 while rst=1.
- Handshake:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_data is sampled only on acceptance.
  - in_valid may be held with no limit; there is no combinational path from in_valid to in_ready.
- States:
  - IDLE: in_ready=1. On acceptance, go to SHIFT, load the shift register, set cnt=0.
  - SHIFT: one bit per cycle. cnt counts 0..WIDTH-1 and is $clog2(WIDTH) bits wide.
  - Leaving SHIFT when cnt==WIDTH-1: go to PARITY if the optional feature is compiled in; otherwise go to IDLE, or reload SHIFT if a new word is accepted that cycle.
  - in_ready=1 in SHIFT only when cnt==WIDTH-1 and parity is not compiled in. This gives back-to-back words with no idle gap.
- Output timing:
  - ser_out and ser_valid are registered.
  - The first bit of a word accepted at edge k is visible after edge k. It stays for exactly one cycle, and each following bit follows in the next cycle.
  - Word latency: acceptance to last bit is WIDTH cycles.
- Shift order:
  - MSB_FIRST=1: shift left and output the top bit.
  - MSB_FIRST=0: shift right and output bit 0.
- busy is 1 from the edge after acceptance until the edge after the final bit, with no deassertion across back-to-back words.
- Boundaries:
  - Reset mid-word discards the remaining bits. ser_valid drops on the next edge; no partial-word recovery.
  - in_valid while not ready leaves in_data unsampled and state unchanged.
  - in_valid=0 at the last bit returns to IDLE, and ser_out goes to IDLE_BIT on the next edge.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- When defined:
  - PARITY state follows the last data bit.
  - It emits one extra bit, the even parity (XOR of the accepted word), with ser_valid=1.
  - in_ready=1 during PARITY, so back-to-back operation resumes after the parity bit. Each word occupies WIDTH+1 cycles.
- When undefined: no PARITY state, no parity logic, WIDTH cycles per word.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE, SHIFT, PARITY), 2 bits;
  - default WIDTH constant;
  - IDLE_BIT default.
- Sub-module: none needed. The shift register and counter stay inline, and the block is a single module.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1: accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles with ser_valid=1, then ser_valid=0 and ser_out=0.
- Back-to-back 8'hA5 then 8'h3C with in_valid held -> 16 contiguous valid bits with no gap, busy stays 1, in_ready pulses once at cnt=7.
- MSB_FIRST=0: accept 8'h01 -> ser_out 1,0,0,0,0,0,0,0. Drive the detector with this stream -> no detection spurious to the idle level.
- Assert rst at bit 4 of 8'hFF -> ser_valid=0 and busy=0 after the edge, in_ready=1 the cycle after rst drops, next word is sent intact.
- in_valid=1 while busy mid-word with in_data changing -> no sample taken; the current word completes unchanged.
- WORD_SERIALIZER_PARITY_EN defined: accept 8'h07 -> 8 data bits then parity bit 1, 9 valid cycles. 8'h03 -> parity bit 0.
